// File: rtl/au_pkg.sv
// Shared AU library definitions: prefix-architecture encoding and config checks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package au_pkg;

    localparam int AU_ARCH_RIPPLE      = 0;
    localparam int AU_ARCH_SKLANSKY    = 1;
    localparam int AU_ARCH_KOGGE_STONE = 2;
    localparam int AU_ARCH_BRENT_KUNG  = 3;

    // True when arch names one of the implemented prefix networks.
    function automatic bit au_arch_valid(input int arch);
        return (arch >= AU_ARCH_RIPPLE) && (arch <= AU_ARCH_BRENT_KUNG);
    endfunction

endpackage

// File: rtl/au_prefix_or.sv
// Prefix-OR network: y[i] = |x[i:0], structure chosen by ARCH.
// Latency: combinational, depth WIDTH-1 (ripple), log2 (Sklansky/KS), ~2*log2 (BK).
// Backpressure: none, pure combinational leaf.
module au_prefix_or
    import au_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    localparam int L = $clog2(WIDTH);

    if (ARCH == AU_ARCH_RIPPLE) begin : g_ripple
        // Each bit gets its own scope so the chain is a clean net-per-stage.
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic w_o;
            if (i == 0) begin : g_first
                assign w_o = x[0];
            end else begin : g_next
                assign w_o = g_bit[i-1].w_o | x[i];
            end
            assign y[i] = w_o;
        end
    end else if (ARCH == AU_ARCH_SKLANSKY) begin : g_sklansky
        // Stage l: upper half of each 2^l block ORs in the last bit of its lower half.
        for (genvar l = 0; l <= L; l++) begin : g_stg
            logic [WIDTH-1:0] w_v;
            if (l == 0) begin : g_in
                assign w_v = x;
            end else begin : g_op
                for (genvar i = 0; i < WIDTH; i++) begin : g_b
                    if (((i >> (l-1)) & 1) == 1) begin : g_comb
                        assign w_v[i] = g_stg[l-1].w_v[i] | g_stg[l-1].w_v[((i >> (l-1)) << (l-1)) - 1];
                    end else begin : g_pass
                        assign w_v[i] = g_stg[l-1].w_v[i];
                    end
                end
            end
        end
        assign y = g_stg[L].w_v;
    end else if (ARCH == AU_ARCH_KOGGE_STONE) begin : g_kogge_stone
        // Stage l: every bit ORs in the bit 2^(l-1) below it, full fan-out per level.
        for (genvar l = 0; l <= L; l++) begin : g_stg
            logic [WIDTH-1:0] w_v;
            if (l == 0) begin : g_in
                assign w_v = x;
            end else begin : g_op
                for (genvar i = 0; i < WIDTH; i++) begin : g_b
                    if (i >= (1 << (l-1))) begin : g_comb
                        assign w_v[i] = g_stg[l-1].w_v[i] | g_stg[l-1].w_v[i - (1 << (l-1))];
                    end else begin : g_pass
                        assign w_v[i] = g_stg[l-1].w_v[i];
                    end
                end
            end
        end
        assign y = g_stg[L].w_v;
    end else if (ARCH == AU_ARCH_BRENT_KUNG) begin : g_brent_kung
        // Stages 1..L are the up-sweep tree, L+1..2L the down-sweep fill-in.
        for (genvar s = 0; s <= 2*L; s++) begin : g_stg
            logic [WIDTH-1:0] w_v;
            if (s == 0) begin : g_in
                assign w_v = x;
            end else begin : g_op
                localparam int LV = (s <= L) ? (s - 1) : (2*L - s);
                localparam int SP = 1 << LV;
                for (genvar i = 0; i < WIDTH; i++) begin : g_b
                    if ((s <= L) ? (((i + 1) % (2*SP)) == 0)
                                 : ((((i + 1) % (2*SP)) == SP) && (i >= 2*SP))) begin : g_comb
                        assign w_v[i] = g_stg[s-1].w_v[i] | g_stg[s-1].w_v[i - SP];
                    end else begin : g_pass
                        assign w_v[i] = g_stg[s-1].w_v[i];
                    end
                end
            end
        end
        assign y = g_stg[2*L].w_v;
    end else begin : g_bad_arch
        $error("au_prefix_or: unsupported ARCH %0d", ARCH);
        assign y = x;
    end

endmodule

// File: rtl/au_absval.sv
// Two's-complement absolute value: z = a[MSB] ? -a : a (unsigned, most-negative maps to 2^(W-1)).
// Latency: 0 cycles, or exactly 1 cycle when AU_ABSVAL_OUTREG_EN is defined.
// Backpressure: none; accepts one word per cycle unconditionally.
module au_absval
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] z
);

    if (!au_arch_valid(ARCH) || (WIDTH < 2)) begin : g_bad_cfg
        $error("au_absval: unsupported configuration ARCH=%0d WIDTH=%0d", ARCH, WIDTH);
    end

    logic             w_s;
    logic [WIDTH-2:0] w_y;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_abs;

    assign w_s = a[WIDTH-1];

    // w_y[i] = |a[i:0]; bit i of the result flips when any lower bit is set.
    au_prefix_or #(
        .WIDTH (WIDTH - 1),
        .ARCH  (ARCH)
    ) u_prefix (
        .x (a[WIDTH-2:0]),
        .y (w_y)
    );

    assign w_p   = {w_y, 1'b0};
    assign w_abs = a ^ ({WIDTH{w_s}} & w_p);

`ifdef AU_ABSVAL_OUTREG_EN
    logic [WIDTH-1:0] r_z;

    // Output register: cleared asynchronously, reloaded with the new magnitude every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z <= '0;
        end else begin
            r_z <= w_abs;
        end
    end

    assign z = r_z;
`else
    // Clock and reset have no role in the combinational build.
    logic w_unused;
    assign w_unused = clk ^ rst;

    assign z = w_abs;
`endif

endmodule

// File: tb/tb_au_absval.sv
// Bench for au_absval over widths 8/13/32/64 and all four prefix architectures.
// Works in both builds; AU_ABSVAL_OUTREG_EN switches the expected timing.
// Reference: plain arithmetic negation of the signed operand, modulo 2^W.
module tb_au_absval;

    logic        clk;
    logic        rst;
    logic [7:0]  a8;
    logic [12:0] a13;
    logic [31:0] a32;
    logic [63:0] a64;
    logic [7:0]  z8  [4];
    logic [12:0] z13 [4];
    logic [31:0] z32 [4];
    logic [63:0] z64 [4];

    int n_total;
    int n_bad;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        au_absval #(.WIDTH(8),  .ARCH(k)) u8  (.clk(clk), .rst(rst), .a(a8),  .z(z8[k]));
        au_absval #(.WIDTH(13), .ARCH(k)) u13 (.clk(clk), .rst(rst), .a(a13), .z(z13[k]));
        au_absval #(.WIDTH(32), .ARCH(k)) u32 (.clk(clk), .rst(rst), .a(a32), .z(z32[k]));
        au_absval #(.WIDTH(64), .ARCH(k)) u64 (.clk(clk), .rst(rst), .a(a64), .z(z64[k]));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // |a| for a w-bit signed value, as unsigned w-bit.
    function automatic logic [63:0] ref_abs(input logic [63:0] a, input int w);
        logic [63:0] m;
        logic [63:0] v;
        m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        v = a & m;
        if (((v >> (w - 1)) & 64'd1) != 64'd0) begin
            return (64'd0 - v) & m;
        end
        return v;
    endfunction

    // Wait until the new operands are visible on z.
    task automatic settle();
`ifdef AU_ABSVAL_OUTREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    logic [7:0] dir_in  [6];
    logic [7:0] dir_exp [6];

    initial begin
        n_total = 0;
        n_bad   = 0;
        dir_in  = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h81, 8'hA0};
        dir_exp = '{8'h00, 8'h01, 8'h80, 8'h7F, 8'h7F, 8'h60};

        rst = 1'b1;
        a8  = 8'hFF;
        a13 = '0;
        a32 = '0;
        a64 = '0;

        // Reset behaviour and first-edge latency.
        #1;
`ifdef AU_ABSVAL_OUTREG_EN
        for (int k = 0; k < 4; k++) check($sformatf("rst_noedge_a%0d", k), z8[k], 64'h00);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) check($sformatf("rst_held_a%0d", k), z8[k], 64'h00);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("rel_noedge_a%0d", k), z8[k], 64'h00);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) check($sformatf("rel_edge_a%0d", k), z8[k], 64'h01);
`else
        for (int k = 0; k < 4; k++) check($sformatf("comb_rst_ignored_a%0d", k), z8[k], 64'h01);
        rst = 1'b0;
        #1;
`endif

        // Directed WIDTH=8 cases.
        for (int t = 0; t < 6; t++) begin
            a8 = dir_in[t];
            settle();
            for (int k = 0; k < 4; k++)
                check($sformatf("dir8_%02h_a%0d", dir_in[t], k), z8[k], {56'd0, dir_exp[t]});
        end

        // Mid-stream reset with a = 0x90.
        a8 = 8'h90;
        settle();
        for (int k = 0; k < 4; k++) check($sformatf("mid_pre_a%0d", k), z8[k], 64'h70);
        #2;
        rst = 1'b1;
        #1;
`ifdef AU_ABSVAL_OUTREG_EN
        for (int k = 0; k < 4; k++) check($sformatf("mid_async_a%0d", k), z8[k], 64'h00);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) check($sformatf("mid_hold_a%0d", k), z8[k], 64'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) check($sformatf("mid_after_a%0d", k), z8[k], 64'h70);
`else
        for (int k = 0; k < 4; k++) check($sformatf("mid_comb_a%0d", k), z8[k], 64'h70);
        rst = 1'b0;
        #1;
`endif

        // Directed wide cases.
        a32 = 32'h0;                  a64 = 64'h0;
        settle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w32_zero_a%0d", k), z32[k], 64'h0);
            check($sformatf("w64_zero_a%0d", k), z64[k], 64'h0);
        end
        a32 = 32'hFFFF_FFFF;          a64 = {64{1'b1}};
        settle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w32_ones_a%0d", k), z32[k], 64'h1);
            check($sformatf("w64_ones_a%0d", k), z64[k], 64'h1);
        end
        a32 = 32'h8000_0000;          a64 = 64'h8000_0000_0000_0000;
        settle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w32_minneg_a%0d", k), z32[k], 64'h8000_0000);
            check($sformatf("w64_minneg_a%0d", k), z64[k], 64'h8000_0000_0000_0000);
        end
        a64 = 64'h0000_0000_8000_0000;
        settle();
        for (int k = 0; k < 4; k++) check($sformatf("w64_8000_0000_a%0d", k), z64[k], 64'h8000_0000);

        // Exhaustive sweep for WIDTH=13 and WIDTH=8.
        for (int v = 0; v < 8192; v++) begin
            a13 = v[12:0];
            a8  = v[7:0];
            settle();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("ex13_%04h_a%0d", v, k), z13[k], ref_abs({51'd0, a13}, 13));
                if (v < 256)
                    check($sformatf("ex8_%02h_a%0d", v, k), z8[k], ref_abs({56'd0, a8}, 8));
            end
        end

        // Random WIDTH=32 / WIDTH=64 traffic.
        for (int n = 0; n < 10000; n++) begin
            a32 = $urandom;
            a64 = {$urandom, $urandom};
            settle();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rnd32_%08h_a%0d", a32, k), z32[k], ref_abs({32'd0, a32}, 32));
                check($sformatf("rnd64_%016h_a%0d", a64, k), z64[k], ref_abs(a64, 64));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
